shift_sequencer: RTL and testbench

Command-driven controller that sequences an 8-bit right-shift register datapath. It accepts one shift command (load value, shift count, arithmetic/logical mode) through a start/ready handshake. It then issues the load and the exact number of shift-right steps, and reports the result with a one-cycle done pulse. It replaces manual KEY-stepping of the shifter with a single-command interface for higher-level FSMs.

---
 rtl/shift_sequencer_pkg.sv | 14 +
 rtl/shift_sequencer_shift_reg_core.sv | 36 +++
 rtl/shift_sequencer.sv | 116 +++++++++++
 tb/tb_shift_sequencer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer: default sizes and FSM state encoding.
package shift_sequencer_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/shift_sequencer_shift_reg_core.sv
// WIDTH-bit right-shift register with load, logical/arithmetic shift and hold.
// Load has priority over shift, shift over hold.
module shift_reg_core #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load_n,
  input  logic             shift,
  input  logic             arith,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;
  logic             w_fill;

  // Bit shifted into the MSB: sign copy for arithmetic, zero for logical.
  always_comb begin
    w_fill = arith & r_q[WIDTH-1];
  end

  // Register update: reset, then load, then shift, otherwise hold.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_q <= '0;
    end else if (!load_n) begin
      r_q <= data_in;
    end else if (shift) begin
      r_q <= {w_fill, r_q[WIDTH-1:1]};
    end
  end

  assign q = r_q;

endmodule

// File: rtl/shift_sequencer.sv
// Command-driven sequencer: accepts one shift command via start/ready, loads the
// shift register, applies exactly `amount` right shifts, then pulses done.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [CNT_W-1:0] amount,
  input  logic             arith,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  seq_state_t       r_state;
  seq_state_t       w_nextState;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_amount;
  logic             r_arith;
  logic             w_loadN;
  logic             w_shift;
  logic             w_accept;

  assign w_accept = (r_state == IDLE) && start;

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    w_nextState = r_state;
    w_loadN     = 1'b1;
    w_shift     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_nextState = LOAD;
        end
      end
      LOAD: begin
        w_loadN = 1'b0;
        if (r_amount != '0) begin
          w_nextState = SHIFT;
        end else begin
          w_nextState = DONE;
        end
      end
      SHIFT: begin
        w_shift = 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Command latch: captured on the accepting edge so inputs may change afterwards.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_data   <= '0;
      r_amount <= '0;
      r_arith  <= 1'b0;
    end else if (w_accept) begin
      r_data   <= data_in;
      r_amount <= amount;
      r_arith  <= arith;
    end
  end

  // Remaining-shift counter: seeded on load, decremented once per shift edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (r_state == LOAD) begin
      r_cnt <= r_amount;
    end else if (r_state == SHIFT) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  shift_reg_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clock  (clock),
    .reset_n(reset_n),
    .load_n (w_loadN),
    .shift  (w_shift),
    .arith  (r_arith),
    .data_in(r_data),
    .q      (result)
  );

  assign ready = (r_state == IDLE);
  assign busy  = ~ready;
  assign done  = (r_state == DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: vector table, random commands against
// an arithmetic reference model, and hand-written multi-cycle corner cases.
module tb_shift_sequencer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] data_in;
  logic [2:0] amount;
  logic       arith;
  logic       ready;
  logic       busy;
  logic       done;
  logic [7:0] result;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [7:0] data;
    logic [2:0] amt;
    logic       ar;
    logic [7:0] expResult;
  } vec_t;

  vec_t vecs [6];

  shift_sequencer dut (
    .clock  (clock),
    .reset_n(reset_n),
    .start  (start),
    .data_in(data_in),
    .amount (amount),
    .arith  (arith),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clock = ~clock;

  // Reference: right shift of the value as unsigned (logical) or signed (arithmetic).
  function automatic logic [7:0] refShift(logic [7:0] d, logic [2:0] a, logic ar);
    logic signed [7:0] s;
    s = d;
    if (ar) return 8'(s >>> a);
    return d >> a;
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Issue one command, follow it to done, check latency, result and return to idle.
  task automatic applyStimulus(string name, logic [7:0] d, logic [2:0] a, logic ar,
                               logic [7:0] expRes);
    int lat;
    @(negedge clock);
    checkOutput({name, " ready before"}, 32'(ready), 1);
    start = 1'b1; data_in = d; amount = a; arith = ar;
    @(posedge clock);
    lat = 1;
    @(negedge clock);
    start = 1'b0; data_in = 8'($urandom); amount = 3'($urandom); arith = 1'($urandom);
    checkOutput({name, " busy after accept"}, {30'd0, busy, ready}, 32'b10);
    while (!done && lat < 40) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
    end
    checkOutput({name, " latency"}, 32'(lat), 32'(a) + 2);
    checkOutput({name, " result"}, 32'(result), 32'(expRes));
    @(negedge clock);
    checkOutput({name, " idle after done"}, {29'd0, ready, busy, done}, 32'b100);
    checkOutput({name, " result held"}, 32'(result), 32'(expRes));
  endtask

  initial begin
    int doneCount;
    int doneEdges[$];
    logic [7:0] rd;
    logic [2:0] ra;
    logic       rr;

    vecs[0] = '{8'hB4, 3'd2, 1'b0, 8'h2D};
    vecs[1] = '{8'hB4, 3'd3, 1'b1, 8'hF6};
    vecs[2] = '{8'h74, 3'd7, 1'b1, 8'h00};
    vecs[3] = '{8'h5A, 3'd0, 1'b0, 8'h5A};
    vecs[4] = '{8'hFF, 3'd1, 1'b0, 8'h7F};
    vecs[5] = '{8'h81, 3'd7, 1'b1, 8'hFF};

    reset_n = 1'b0; start = 1'b0; data_in = 8'h00; amount = 3'd0; arith = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checkOutput("reset ready/busy/done", {29'd0, ready, busy, done}, 32'b100);
    checkOutput("reset result", 32'(result), 32'h00);

    for (int i = 0; i < 6; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].data, vecs[i].amt, vecs[i].ar,
                    vecs[i].expResult);
    end

    for (int i = 0; i < 25; i++) begin
      rd = 8'($urandom); ra = 3'($urandom); rr = 1'($urandom);
      applyStimulus($sformatf("rand%0d", i), rd, ra, rr, refShift(rd, ra, rr));
    end

    // Start pulsed during SHIFT must be dropped.
    @(negedge clock);
    start = 1'b1; data_in = 8'h80; amount = 3'd4; arith = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    @(posedge clock);
    @(negedge clock);
    start = 1'b1; data_in = 8'hFF; amount = 3'd0; arith = 1'b0;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    doneCount = 0;
    for (int c = 0; c < 15; c++) begin
      if (done) begin
        doneCount++;
        checkOutput("busy-ignore result at done", 32'(result), 32'hF8);
      end
      @(negedge clock);
    end
    checkOutput("busy-ignore done count", 32'(doneCount), 1);
    checkOutput("busy-ignore final result", 32'(result), 32'hF8);

    // Reset during SHIFT aborts without a done pulse.
    @(negedge clock);
    start = 1'b1; data_in = 8'hC3; amount = 3'd6; arith = 1'b0;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("mid-op in shift", 32'(busy), 1);
    reset_n = 1'b0;
    @(posedge clock);
    @(negedge clock);
    checkOutput("mid-op reset state", {29'd0, ready, busy, done}, 32'b100);
    checkOutput("mid-op reset result", 32'(result), 32'h00);
    reset_n = 1'b1;
    doneCount = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (done) doneCount++;
    end
    checkOutput("mid-op no done", 32'(doneCount), 0);
    applyStimulus("after reset", 8'hC3, 3'd6, 1'b1, 8'hFF);

    // start held high: one command every amount+3 cycles.
    @(negedge clock);
    start = 1'b1; data_in = 8'h96; amount = 3'd1; arith = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clock);
      if (done) begin
        doneEdges.push_back(c);
        checkOutput("held-start result", 32'(result), 32'h4B);
      end
    end
    start = 1'b0;
    checkOutput("held-start done count", 32'(doneEdges.size()), 3);
    if (doneEdges.size() >= 2)
      checkOutput("held-start period", 32'(doneEdges[1] - doneEdges[0]), 4);
    else
      checkOutput("held-start period", 32'(0), 4);
    repeat (6) @(negedge clock);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
